// File: rtl/w5300_pkg.sv
// Shared W5300 bus widths, arbiter state encoding and register map constants
// used by the parallel-bus arbiter and its requesters.
package w5300_pkg;

    localparam int W5300_ADDR_W = 10;
    localparam int W5300_DATA_W = 16;

    typedef logic [W5300_ADDR_W-1:0] w5300_addr_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Direct-mode byte addresses; socket registers repeat every stride.
    localparam w5300_addr_t W5300_MR          = 10'h000;
    localparam w5300_addr_t W5300_IR          = 10'h002;
    localparam w5300_addr_t W5300_IMR         = 10'h004;
    localparam w5300_addr_t W5300_SN_BASE     = 10'h200;
    localparam w5300_addr_t W5300_SN_STRIDE   = 10'h040;
    localparam w5300_addr_t W5300_SN_TX_FIFOR = 10'h02E;
    localparam w5300_addr_t W5300_SN_RX_FIFOR = 10'h030;

    function automatic w5300_addr_t sn_reg(input logic [2:0] sock, input w5300_addr_t off);
        return W5300_SN_BASE + w5300_addr_t'({sock, 6'b00_0000}) + off;
    endfunction

endpackage

// File: rtl/w5300_rr_pick.sv
// Combinational round-robin picker: scans requests upward from rr_ptr_i,
// restricted to the lock owner while a lock is being held.
module w5300_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      rr_ptr_i,
    input  logic               lock_valid_i,
    input  logic [IW-1:0]      lock_own_i,
    output logic [IW-1:0]      grant_o,
    output logic               found_o
);

    logic [NUM_REQ-1:0] elig;
    logic [IW:0]        pos;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign elig[gi] = req_i[gi] & (~lock_valid_i | (lock_own_i == IW'(gi)));
        end
    endgenerate

    // One extra bit on pos keeps the wrap-around compare exact for any NUM_REQ.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_REQ)) begin
                pos = pos - (IW+1)'(NUM_REQ);
            end
            if (!found_o && elig[pos[IW-1:0]]) begin
                found_o = 1'b1;
                grant_o = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Shares the W5300 parallel-bus interface between NUM_REQ requesters, one
// transaction at a time, with round-robin fairness, lock sequences and a watchdog.
module w5300_bus_arbiter
    import w5300_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                             clk,
    input  logic                             i_rst_n,
    input  logic [NUM_REQ-1:0]               m_req,
    input  logic [NUM_REQ-1:0]               m_lock,
    input  logic [NUM_REQ-1:0]               m_we,
    input  logic [NUM_REQ*W5300_ADDR_W-1:0]  m_addr,
    input  logic [NUM_REQ*W5300_DATA_W-1:0]  m_wdata,
    output logic [NUM_REQ-1:0]               m_rsp_valid,
    output logic                             m_rsp_err,
    output logic [W5300_DATA_W-1:0]          m_rdata,
    output logic                             bus_req_valid,
    input  logic                             bus_req_ready,
    output logic                             bus_we,
    output logic [W5300_ADDR_W-1:0]          bus_addr,
    output logic [W5300_DATA_W-1:0]          bus_wdata,
    input  logic                             bus_rsp_valid,
    input  logic [W5300_DATA_W-1:0]          bus_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e        state_q;
    logic [IW-1:0]     sel_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     lock_own_q;
    logic              lock_valid_q;
    logic              lock_req_q;
    logic [CW-1:0]     cnt_q;

    logic [IW-1:0]      grant;
    logic               found;
    logic               lock_hold;
    logic [IW-1:0]      rr_ptr_d;
    logic [NUM_REQ-1:0] rsp_vec_d;
    logic               timeout_d;

    logic [W5300_ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [W5300_DATA_W-1:0] wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = m_addr[gi*W5300_ADDR_W +: W5300_ADDR_W];
            assign wdata_arr[gi] = m_wdata[gi*W5300_DATA_W +: W5300_DATA_W];
        end
    endgenerate

    // A lock is honoured only while its owner keeps m_lock asserted.
    assign lock_hold = lock_valid_q & m_lock[lock_own_q];
    assign rr_ptr_d  = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + IW'(1);
    assign rsp_vec_d = NUM_REQ'(1) << sel_q;
    assign timeout_d = (cnt_q == CW'(TIMEOUT - 1));

    w5300_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i        (m_req),
        .rr_ptr_i     (rr_ptr_q),
        .lock_valid_i (lock_hold),
        .lock_own_i   (lock_own_q),
        .grant_o      (grant),
        .found_o      (found)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ARB_IDLE;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            lock_own_q    <= '0;
            lock_valid_q  <= 1'b0;
            lock_req_q    <= 1'b0;
            cnt_q         <= '0;
            m_rsp_valid   <= '0;
            m_rsp_err     <= 1'b0;
            m_rdata       <= '0;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
        end else begin
            m_rsp_valid <= '0;
            m_rsp_err   <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (lock_valid_q && !m_lock[lock_own_q]) begin
                        lock_valid_q <= 1'b0;
                    end
                    // Skip the pulse cycle so a finishing requester can drop m_req first.
                    if (found && (m_rsp_valid == '0)) begin
                        sel_q         <= grant;
                        bus_we        <= m_we[grant];
                        bus_addr      <= addr_arr[grant];
                        bus_wdata     <= wdata_arr[grant];
                        lock_req_q    <= m_lock[grant];
                        bus_req_valid <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (timeout_d) begin
                        m_rsp_valid   <= rsp_vec_d;
                        m_rsp_err     <= 1'b1;
                        m_rdata       <= '0;
                        bus_req_valid <= 1'b0;
                        lock_valid_q  <= 1'b0;
                        rr_ptr_q      <= rr_ptr_d;
                        state_q       <= ARB_IDLE;
                    end else if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state_q       <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (bus_rsp_valid) begin
                        m_rsp_valid  <= rsp_vec_d;
                        m_rdata      <= bus_rdata;
                        rr_ptr_q     <= rr_ptr_d;
                        lock_valid_q <= lock_req_q;
                        lock_own_q   <= sel_q;
                        state_q      <= ARB_IDLE;
                    end else if (timeout_d) begin
                        m_rsp_valid  <= rsp_vec_d;
                        m_rsp_err    <= 1'b1;
                        m_rdata      <= '0;
                        lock_valid_q <= 1'b0;
                        rr_ptr_q     <= rr_ptr_d;
                        state_q      <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Scoreboard bench for w5300_bus_arbiter: a bus responder model checks issued
// transactions and a monitor compares every completion against queued expectations.
module tb_w5300_bus_arbiter;
    import w5300_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    typedef struct {
        int          idx;
        bit          err;
        bit          chk_data;
        logic [15:0] rdata;
        int          lat;      // 0: one cycle after bus response, else cycles after issue
    } exp_t;

    typedef struct {
        bit          we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        int          rdly;
        int          rspdly;
        bit          respond;
        logic [15:0] rdata;
    } bus_t;

    logic          clk;
    logic          i_rst_n;
    logic [N-1:0]  m_req, m_lock, m_we, lock_en;
    logic [N*10-1:0] m_addr;
    logic [N*16-1:0] m_wdata;
    logic [N-1:0]  m_rsp_valid;
    logic          m_rsp_err;
    logic [15:0]   m_rdata;
    logic          bus_req_valid, bus_req_ready, bus_we;
    logic [9:0]    bus_addr;
    logic [15:0]   bus_wdata;
    logic          bus_rsp_valid;
    logic [15:0]   bus_rdata;

    int   want [N];
    int   got  [N];
    int   cyc = 0;
    int   last_issue_cyc = 0;
    int   rsp_cyc = 0;
    bit   bus_busy = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t expq[$];
    bus_t script[$];

    w5300_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .m_req         (m_req),
        .m_lock        (m_lock),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rsp_valid   (m_rsp_valid),
        .m_rsp_err     (m_rsp_err),
        .m_rdata       (m_rdata),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Requester i holds m_req until all of its queued accesses have completed.
    assign m_req  = {want[1] != got[1], want[0] != got[0]};
    assign m_lock = lock_en & m_req;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Bus-side model: checks each issued request and answers per script.
    initial begin
        bus_t e;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = '0;
        forever begin
            @(negedge clk);
            if (i_rst_n && bus_req_valid) begin
                if (script.size() == 0) begin
                    chk("spurious_issue", 32'(bus_req_valid), 32'd0);
                end else begin
                    bus_busy = 1'b1;
                    e = script.pop_front();
                    last_issue_cyc = cyc;
                    chk("issue_addr", 32'(bus_addr), 32'(e.addr));
                    chk("issue_we", 32'(bus_we), 32'(e.we));
                    if (e.we) chk("issue_wdata", 32'(bus_wdata), 32'(e.wdata));
                    for (int d = 0; d < e.rdly; d++) begin
                        @(negedge clk);
                        chk("hold_valid", 32'(bus_req_valid), 32'd1);
                        chk("hold_addr", 32'(bus_addr), 32'(e.addr));
                        chk("hold_wdata", 32'(bus_wdata), 32'(e.wdata));
                    end
                    bus_req_ready = 1'b1;
                    @(negedge clk);
                    bus_req_ready = 1'b0;
                    chk("valid_drop", 32'(bus_req_valid), 32'd0);
                    if (e.respond) begin
                        repeat (e.rspdly) @(negedge clk);
                        bus_rsp_valid = 1'b1;
                        bus_rdata     = e.rdata;
                        rsp_cyc       = cyc;
                        @(negedge clk);
                        bus_rsp_valid = 1'b0;
                    end
                    bus_busy = 1'b0;
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rst_n && (m_rsp_valid != '0)) begin
                if (expq.size() == 0) begin
                    chk("unexpected_rsp", 32'(m_rsp_valid), 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_valid", 32'(m_rsp_valid), 32'd1 << e.idx);
                    chk("rsp_err", 32'(m_rsp_err), 32'(e.err));
                    if (e.chk_data) chk("rsp_rdata", 32'(m_rdata), 32'(e.rdata));
                    if (e.lat == 0) chk("rsp_latency", 32'(cyc - rsp_cyc), 32'd1);
                    else            chk("timeout_latency", 32'(cyc - last_issue_cyc), 32'(e.lat));
                end
                for (int i = 0; i < N; i++) if (m_rsp_valid[i]) got[i]++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests, expected completion", n_tests);
        $fatal(1);
    end

    task automatic start(input int i, input bit we, input logic [9:0] addr,
                         input logic [15:0] wd, input bit lk, input int n);
        m_we[i]            = we;
        m_addr[i*10 +: 10] = addr;
        m_wdata[i*16 +: 16] = wd;
        lock_en[i]         = lk;
        want[i]            = want[i] + n;
    endtask

    task automatic push_bus(input bit we, input logic [9:0] addr, input logic [15:0] wd,
                            input int rdly, input int rspdly, input bit respond, input logic [15:0] rd);
        bus_t b;
        b.we = we; b.addr = addr; b.wdata = wd; b.rdly = rdly;
        b.rspdly = rspdly; b.respond = respond; b.rdata = rd;
        script.push_back(b);
    endtask

    task automatic push_exp(input int idx, input bit err, input bit cd, input logic [15:0] rd, input int lat);
        exp_t x;
        x.idx = idx; x.err = err; x.chk_data = cd; x.rdata = rd; x.lat = lat;
        expq.push_back(x);
    endtask

    task automatic wait_done(input string name, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            if (expq.size() == 0 && script.size() == 0 && !bus_busy) break;
            @(negedge clk);
        end
        if (k == max) chk(name, 32'(expq.size() + script.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [9:0] rx0, tx0;
        rx0 = sn_reg(3'd0, W5300_SN_RX_FIFOR);
        tx0 = sn_reg(3'd0, W5300_SN_TX_FIFOR);
        i_rst_n = 1'b0;
        m_we = '0; m_addr = '0; m_wdata = '0; lock_en = '0;
        for (int i = 0; i < N; i++) begin want[i] = 0; got[i] = 0; end
        repeat (3) @(negedge clk);
        chk("rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_m_rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("rst_m_rsp_err", 32'(m_rsp_err), 32'd0);
        chk("rst_m_rdata", 32'(m_rdata), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // 1: single read, one-cycle capture latency
        push_bus(1'b0, W5300_MR, 16'h0000, 0, 0, 1'b1, 16'hB800);
        push_exp(0, 1'b0, 1'b1, 16'hB800, 0);
        start(0, 1'b0, W5300_MR, 16'h0000, 1'b0, 1);
        @(negedge clk);
        chk("t1_latency_valid", 32'(bus_req_valid), 32'd1);
        chk("t1_bus_we", 32'(bus_we), 32'd0);
        wait_done("t1_wait", 60);

        // single write from requester 1 brings rr_ptr back to 0
        push_bus(1'b1, W5300_IMR, 16'h00FF, 0, 1, 1'b1, 16'h0000);
        push_exp(1, 1'b0, 1'b0, 16'h0000, 0);
        start(1, 1'b1, W5300_IMR, 16'h00FF, 1'b0, 1);
        wait_done("t1b_wait", 60);

        // 2: round robin with both requesters busy
        push_bus(1'b0, W5300_IR, 16'h0000, 0, 0, 1'b1, 16'h1111);
        push_bus(1'b1, W5300_IMR, 16'h1234, 0, 0, 1'b1, 16'h2222);
        push_bus(1'b0, W5300_IR, 16'h0000, 0, 1, 1'b1, 16'h3333);
        push_bus(1'b1, W5300_IMR, 16'h1234, 0, 0, 1'b1, 16'h4444);
        push_exp(0, 1'b0, 1'b1, 16'h1111, 0);
        push_exp(1, 1'b0, 1'b0, 16'h0000, 0);
        push_exp(0, 1'b0, 1'b1, 16'h3333, 0);
        push_exp(1, 1'b0, 1'b0, 16'h0000, 0);
        start(0, 1'b0, W5300_IR, 16'h0000, 1'b0, 2);
        start(1, 1'b1, W5300_IMR, 16'h1234, 1'b0, 2);
        wait_done("t2_wait", 200);

        // 3: locked burst of RX FIFO reads; requester 1 waits for the lock to drop
        push_bus(1'b0, rx0, 16'h0000, 0, 0, 1'b1, 16'hAA01);
        push_bus(1'b0, rx0, 16'h0000, 0, 0, 1'b1, 16'hAA02);
        push_bus(1'b0, rx0, 16'h0000, 0, 0, 1'b1, 16'hAA03);
        push_bus(1'b1, tx0, 16'h5555, 0, 0, 1'b1, 16'h0000);
        push_exp(0, 1'b0, 1'b1, 16'hAA01, 0);
        push_exp(0, 1'b0, 1'b1, 16'hAA02, 0);
        push_exp(0, 1'b0, 1'b1, 16'hAA03, 0);
        push_exp(1, 1'b0, 1'b0, 16'h0000, 0);
        start(0, 1'b0, rx0, 16'h0000, 1'b1, 3);
        start(1, 1'b1, tx0, 16'h5555, 1'b0, 1);
        wait_done("t3_wait", 200);
        lock_en = '0;

        // 4: five cycles of backpressure
        push_bus(1'b1, tx0, 16'hA5C3, 5, 2, 1'b1, 16'hDEAD);
        push_exp(0, 1'b0, 1'b0, 16'h0000, 0);
        start(0, 1'b1, tx0, 16'hA5C3, 1'b0, 1);
        wait_done("t4_wait", 80);

        // 5: watchdog expiry, late response ignored, then a normal access
        push_bus(1'b0, W5300_IMR, 16'h0000, 0, 20, 1'b1, 16'hBEEF);
        push_exp(1, 1'b1, 1'b1, 16'h0000, TO);
        start(1, 1'b0, W5300_IMR, 16'h0000, 1'b0, 1);
        wait_done("t5_wait", 120);
        push_bus(1'b0, W5300_IR, 16'h0000, 0, 0, 1'b1, 16'h0F0F);
        push_exp(1, 1'b0, 1'b1, 16'h0F0F, 0);
        start(1, 1'b0, W5300_IR, 16'h0000, 1'b0, 1);
        wait_done("t5b_wait", 60);

        // 6: reset while waiting for the bus response
        push_bus(1'b0, W5300_MR, 16'h0000, 0, 0, 1'b1, 16'h0001);
        push_exp(0, 1'b0, 1'b1, 16'h0001, 0);
        start(0, 1'b0, W5300_MR, 16'h0000, 1'b0, 1);
        wait_done("t6a_wait", 60);
        push_bus(1'b0, rx0, 16'h0000, 0, 0, 1'b0, 16'h0000);
        start(1, 1'b0, rx0, 16'h0000, 1'b0, 1);
        wait_done("t6b_wait", 60);
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
        chk("t6_rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("t6_rst_m_rdata", 32'(m_rdata), 32'd0);
        chk("t6_rst_m_rsp_valid", 32'(m_rsp_valid), 32'd0);
        want[1] = want[1] - 1;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (30) @(negedge clk);
        push_bus(1'b0, W5300_MR, 16'h0000, 0, 0, 1'b1, 16'hB801);
        push_bus(1'b0, W5300_IMR, 16'h0000, 0, 0, 1'b1, 16'hC002);
        push_exp(0, 1'b0, 1'b1, 16'hB801, 0);
        push_exp(1, 1'b0, 1'b1, 16'hC002, 0);
        start(0, 1'b0, W5300_MR, 16'h0000, 1'b0, 1);
        start(1, 1'b0, W5300_IMR, 16'h0000, 1'b0, 1);
        wait_done("t6c_wait", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/w5300_bus_arbiter.md
Name: w5300_bus_arbiter

Overview:
Shares the single W5300 asynchronous parallel-bus interface between NUM_REQ internal requesters, e.g. the chip init/config sequencer, the interrupt service engine and the socket RX/TX data movers. The arbiter issues one register transaction at a time to the parallel-interface block, with round-robin fairness. A lock lets one requester run uninterrupted multi-access sequences, such as back-to-back Sn_RX_FIFOR reads. A watchdog returns an error response if the bus never answers.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 1023, max cycles from bus_req_valid rising to bus_rsp_valid before error completion

Ports:
clk  input  1  system clock
i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low
m_req  input  NUM_REQ  per-requester request level; held until that requester's m_rsp_valid
m_lock  input  NUM_REQ  per-requester lock request, sampled with m_req at capture
m_we  input  NUM_REQ  1 = write, 0 = read
m_addr  input  NUM_REQ*10  flattened W5300 addresses, requester i at [10i+9:10i]
m_wdata  input  NUM_REQ*16  flattened write data, requester i at [16i+15:16i]
m_rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse
m_rsp_err  output  1  qualifies m_rsp_valid; 1 = timed out
m_rdata  output  16  read data, valid with m_rsp_valid
bus_req_valid  output  1  transaction request to parallel interface
bus_req_ready  input  1  parallel interface accepts request
bus_we  output  1  registered copy of selected m_we
bus_addr  output  10  registered address
bus_wdata  output  16  registered write data
bus_rsp_valid  input  1  transaction done; bus_rdata valid
bus_rdata  input  16  read data from parallel interface

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0; lock_valid = 0; timeout counter = 0.
- Reset asserted mid-transaction aborts it. No response is ever produced for the aborted request.
- States: IDLE, ISSUE, WAIT.
- IDLE, selection:
  - If lock_valid and m_lock[lock_own] = 0, the lock is released this cycle and normal arbitration applies.
  - If lock_valid and m_lock[lock_own] = 1, only lock_own is eligible. All other requests wait.
  - Otherwise pick the first asserted m_req scanning from rr_ptr upward, modulo NUM_REQ.
- IDLE, capture: on selection, register sel, m_we/m_addr/m_wdata[sel] into bus_* and lock_req = m_lock[sel]. Set bus_req_valid = 1 and go to ISSUE. The counter is cleared.
- Latency: m_req seen in IDLE at cycle N gives bus_req_valid high at N+1.
- ISSUE: hold bus_req_valid and bus_* stable until bus_req_ready = 1. Then bus_req_valid goes 0 next cycle and the state goes to WAIT.
- WAIT, on bus_rsp_valid:
  - Register m_rdata = bus_rdata (writes return bus_rdata unchanged, don't-care) and pulse m_rsp_valid[sel] for one cycle with m_rsp_err = 0. The pulse appears the cycle after bus_rsp_valid.
  - Set rr_ptr = (sel+1) mod NUM_REQ.
  - Set lock_valid = lock_req and lock_own = sel.
  - Return to IDLE.
- Timeout: the counter increments every cycle in ISSUE and WAIT. When it reaches TIMEOUT-1 with no bus_rsp_valid that cycle:
  - m_rsp_valid[sel] pulses with m_rsp_err = 1 and m_rdata = 16'h0000.
  - bus_req_valid = 0, lock_valid = 0, rr_ptr advances, state returns to IDLE.
- bus_rsp_valid and timeout in the same cycle: the response wins and m_rsp_err = 0.
- bus_rsp_valid outside WAIT (stale or late) is ignored.
- Earliest re-issue: the requester may keep m_req high for its next access. It is re-arbitrated in the IDLE cycle following the m_rsp_valid pulse.
- A requester dropping m_req during ISSUE/WAIT does not cancel the transaction. The response is still delivered.
- Widths: sel and rr_ptr are clog2(NUM_REQ) bits; counter is clog2(TIMEOUT+1) bits.

Decomposition:
- Package w5300_pkg:
  - W5300_ADDR_W = 10, W5300_DATA_W = 16
  - arbiter state enum (IDLE/ISSUE/WAIT)
  - W5300 register address constants (MR, IR, IMR, Sn_* base/stride, Sn_TX_FIFOR, Sn_RX_FIFOR)
- Sub-module w5300_rr_pick: combinational round-robin picker. Inputs are the request vector, rr_ptr, lock_valid and lock_own. Outputs are the grant index and a found flag.

Test Plan:
1. Single read: req0 read addr 10'h000 → bus_addr = 10'h000 and bus_we = 0 next cycle. Bus answers 16'hB800 after ready. One cycle later m_rsp_valid = 2'b01 and m_rdata = 16'hB800, err = 0.
2. Round-robin: both requesters hold m_req continuously for 4 transactions, rr_ptr = 0 → service order 0, 1, 0, 1.
3. Lock: req0 holds m_lock = 1 for 3 reads of Sn_RX_FIFOR while req1 requests → req0 served 3 times consecutively. req1 is served after req0 drops m_lock.
4. Backpressure: bus_req_ready low for 5 cycles → bus_req_valid, bus_addr and bus_wdata stay stable for all 5 cycles. The request is issued exactly once.
5. Timeout: TIMEOUT = 16, bus never responds → m_rsp_valid with err = 1 and m_rdata = 0 exactly 16 cycles after bus_req_valid rose. A later stray bus_rsp_valid is ignored, and the next request proceeds normally.
6. Reset mid-WAIT: assert i_rst_n low → all outputs 0 immediately. After release, no response pulse and rr_ptr = 0.
